// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// wait-counter width and the default memory timeout.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MEMWAIT = 2'b01,
        ST_ERROR   = 2'b10
    } state_t;

    localparam int CNT_W               = 16;
    localparam int TIMEOUT_CYC_DEFAULT = 255;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector: the load in EX writes a register
// that the instruction in ID needs as a source.
module hazard_detect (
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rw,
    output logic       o_hazard
);

    logic w_rs_match;
    logic w_rt_match;

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_rs_match = (i_ex_rw == i_id_rs);
    assign w_rt_match = i_id_uses_rt && (i_ex_rw == i_id_rt);
    assign o_hazard   = i_ex_mem_read && (i_ex_rw != 5'd0) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, branch flushes and a
// RUN/MEMWAIT/ERROR machine that freezes the pipe on slow data memory.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UsesRt,
    input  logic        ID_BranchTaken,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Rw,
    input  logic        MEM_MemAccess,
    input  logic        dmem_ready,
    output logic        PC_En,
    output logic        IFID_En,
    output logic        IDEX_En,
    output logic        EXMEM_En,
    output logic        MEMWB_En,
    output logic        IFID_Flush,
    output logic        IDEX_Flush,
    output logic        dmem_req,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt,
    output logic [1:0]  o_dbg_state
);

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT_CYC);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_next;
    logic [15:0]      r_stall_cnt;

    logic w_hazard;
    logic w_pipe_go;
    logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
    logic w_ifid_flush, w_idex_flush, w_dmem_req, w_timeout;

    hazard_detect u_hazard_detect (
        .i_id_rs       (ID_Rs),
        .i_id_rt       (ID_Rt),
        .i_id_uses_rt  (ID_UsesRt),
        .i_ex_mem_read (EX_MemRead),
        .i_ex_rw       (EX_Rw),
        .o_hazard      (w_hazard)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_pipe_go       = 1'b0;
        w_dmem_req      = 1'b0;
        w_timeout       = 1'b0;
        w_pc_en         = 1'b0;
        w_ifid_en       = 1'b0;
        w_idex_en       = 1'b0;
        w_exmem_en      = 1'b0;
        w_memwb_en      = 1'b0;
        w_ifid_flush    = 1'b0;
        w_idex_flush    = 1'b0;

        case (r_state)
            ST_RUN: begin
                w_dmem_req = MEM_MemAccess;
                if (MEM_MemAccess && !dmem_ready) begin
                    w_next_state    = ST_MEMWAIT;
                    w_wait_cnt_next = CNT_W'(1);
                end else begin
                    w_pipe_go = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                w_dmem_req = 1'b1;
                if (dmem_ready) begin
                    w_next_state = ST_RUN;
                    w_pipe_go    = 1'b1;
                end else if (r_wait_cnt == LP_TIMEOUT) begin
                    w_next_state = ST_ERROR;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + CNT_W'(1);
                end
            end
            ST_ERROR: begin
                w_timeout = 1'b1;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase

        // A pending load-use bubble overrides the branch flush: the branch
        // operands are not ready, so the branch re-resolves next cycle.
        if (w_pipe_go) begin
            w_idex_en  = 1'b1;
            w_exmem_en = 1'b1;
            w_memwb_en = 1'b1;
            if (w_hazard) begin
                w_idex_flush = 1'b1;
            end else begin
                w_pc_en      = 1'b1;
                w_ifid_en    = 1'b1;
                w_ifid_flush = ID_BranchTaken;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!PC_En && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign PC_En       = w_pc_en      & ~reset;
    assign IFID_En     = w_ifid_en    & ~reset;
    assign IDEX_En     = w_idex_en    & ~reset;
    assign EXMEM_En    = w_exmem_en   & ~reset;
    assign MEMWB_En    = w_memwb_en   & ~reset;
    assign IFID_Flush  = w_ifid_flush & ~reset;
    assign IDEX_Flush  = w_idex_flush & ~reset;
    assign dmem_req    = w_dmem_req   & ~reset;
    assign mem_timeout = w_timeout    & ~reset;
    assign stall_cnt   = r_stall_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: each stimulus cycle queues its expected
// output vector; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  localparam int W = 27;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  ID_Rs = '0, ID_Rt = '0, EX_Rw = '0;
  logic        ID_UsesRt = 1'b0, ID_BranchTaken = 1'b0, EX_MemRead = 1'b0;
  logic        MEM_MemAccess = 1'b0, dmem_ready = 1'b0;
  logic        PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En;
  logic        IFID_Flush, IDEX_Flush, dmem_req, mem_timeout;
  logic [15:0] stall_cnt;
  logic [1:0]  o_dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_BranchTaken(ID_BranchTaken), .EX_MemRead(EX_MemRead), .EX_Rw(EX_Rw),
    .MEM_MemAccess(MEM_MemAccess), .dmem_ready(dmem_ready),
    .PC_En(PC_En), .IFID_En(IFID_En), .IDEX_En(IDEX_En),
    .EXMEM_En(EXMEM_En), .MEMWB_En(MEMWB_En),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .dmem_req(dmem_req), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .o_dbg_state(o_dbg_state)
  );

  // Expected vector layout: {PC,IFID,IDEX,EXMEM,MEMWB en, IFID,IDEX flush, req, timeout, stall_cnt, state}
  task automatic step(input string name, input logic rst,
                      input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                      input logic br, input logic exmr, input logic [4:0] exrw,
                      input logic macc, input logic rdy,
                      input logic [4:0] en, input logic [1:0] fl, input logic req,
                      input logic to, input logic [15:0] sc, input logic [1:0] st);
    @(posedge clk);
    #1;
    reset = rst; ID_Rs = rs; ID_Rt = rt; ID_UsesRt = ut; ID_BranchTaken = br;
    EX_MemRead = exmr; EX_Rw = exrw; MEM_MemAccess = macc; dmem_ready = rdy;
    exp_q.push_back({en, fl, req, to, sc, st});
    name_q.push_back(name);
  endtask

  task automatic check_state(input string name, input logic [4:0] en,
                             input logic [1:0] fl, input logic req, input logic to,
                             input logic [1:0] st);
    #1;
    checks++;
    if ({PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En} !== en ||
        {IFID_Flush, IDEX_Flush} !== fl || dmem_req !== req ||
        mem_timeout !== to || o_dbg_state !== st) begin
      failures++;
      $display("FAIL %s: en=%05b fl=%02b req=%b to=%b st=%0d", name,
               {PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En},
               {IFID_Flush, IDEX_Flush}, dmem_req, mem_timeout, o_dbg_state);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v;
      logic [W-1:0] got_v;
      string        nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      got_v = {PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En, IFID_Flush, IDEX_Flush,
               dmem_req, mem_timeout, stall_cnt, o_dbg_state};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL %s: got=%07h expected=%07h", nm, got_v, exp_v);
      end
    end
  end

  initial begin
    //   name           rst rs     rt     ut br mr rw     ma rdy  en        fl     rq to sc      st
    step("reset_hold",   1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0,  5'b00000, 2'b00, 0, 0, 16'd0, 2'd0);
    check_state("reset_state", 5'b00000, 2'b00, 1'b0, 1'b0, 2'd0);
    step("run_idle",     0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0,  5'b11111, 2'b00, 0, 0, 16'd0, 2'd0);
    step("lu_rs",        0, 5'd8,  5'd0,  0, 0, 1, 5'd8,  0, 0,  5'b00111, 2'b01, 0, 0, 16'd0, 2'd0);
    step("after_lu",     0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0,  5'b11111, 2'b00, 0, 0, 16'd1, 2'd0);
    step("r0_no_haz",    0, 5'd0,  5'd0,  0, 0, 1, 5'd0,  0, 0,  5'b11111, 2'b00, 0, 0, 16'd1, 2'd0);
    step("rt_unused",    0, 5'd3,  5'd5,  0, 0, 1, 5'd5,  0, 0,  5'b11111, 2'b00, 0, 0, 16'd1, 2'd0);
    step("lu_rt",        0, 5'd3,  5'd5,  1, 0, 1, 5'd5,  0, 0,  5'b00111, 2'b01, 0, 0, 16'd1, 2'd0);
    step("branch",       0, 5'd0,  5'd0,  0, 1, 0, 5'd0,  0, 0,  5'b11111, 2'b10, 0, 0, 16'd2, 2'd0);
    step("br_plus_lu",   0, 5'd8,  5'd0,  0, 1, 1, 5'd8,  0, 0,  5'b00111, 2'b01, 0, 0, 16'd2, 2'd0);
    step("br_after_lu",  0, 5'd8,  5'd0,  0, 1, 0, 5'd0,  0, 0,  5'b11111, 2'b10, 0, 0, 16'd3, 2'd0);
    step("zero_wait",    0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 1,  5'b11111, 2'b00, 1, 0, 16'd3, 2'd0);
    step("mw_first",     0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 0,  5'b00000, 2'b00, 1, 0, 16'd3, 2'd0);
    step("mw_wait1",     0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 0,  5'b00000, 2'b00, 1, 0, 16'd4, 2'd1);
    step("mw_wait2",     0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 0,  5'b00000, 2'b00, 1, 0, 16'd5, 2'd1);
    step("mw_ready",     0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 1,  5'b11111, 2'b00, 1, 0, 16'd6, 2'd1);
    step("mw_back_run",  0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0,  5'b11111, 2'b00, 0, 0, 16'd6, 2'd0);
    step("mem_prio",     0, 5'd8,  5'd0,  0, 1, 1, 5'd8,  1, 0,  5'b00000, 2'b00, 1, 0, 16'd6, 2'd0);
    step("mw_rdy_lu",    0, 5'd8,  5'd0,  0, 1, 1, 5'd8,  1, 1,  5'b00111, 2'b01, 1, 0, 16'd7, 2'd1);
    step("prio_clear",   0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0,  5'b11111, 2'b00, 0, 0, 16'd8, 2'd0);
    step("rst_mw_a",     0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 0,  5'b00000, 2'b00, 1, 0, 16'd8, 2'd0);
    step("rst_mw_b",     0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 0,  5'b00000, 2'b00, 1, 0, 16'd9, 2'd1);
    step("rst_in_mw",    1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 0,  5'b00000, 2'b00, 0, 0, 16'd0, 2'd0);
    step("post_rst_zw",  0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 1,  5'b11111, 2'b00, 1, 0, 16'd0, 2'd0);
    step("to_enter",     0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 0,  5'b00000, 2'b00, 1, 0, 16'd0, 2'd0);
    step("to_w1",        0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 0,  5'b00000, 2'b00, 1, 0, 16'd1, 2'd1);
    step("to_w2",        0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 0,  5'b00000, 2'b00, 1, 0, 16'd2, 2'd1);
    step("to_w3",        0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 0,  5'b00000, 2'b00, 1, 0, 16'd3, 2'd1);
    step("to_w4",        0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 0,  5'b00000, 2'b00, 1, 0, 16'd4, 2'd1);
    step("error_rdy",    0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 1,  5'b00000, 2'b00, 0, 1, 16'd5, 2'd2);
    step("error_stick",  0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0,  5'b00000, 2'b00, 0, 1, 16'd6, 2'd2);
    check_state("expired_wait", 5'b00000, 2'b00, 1'b0, 1'b1, 2'd2);
    step("rst_in_err",   1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0,  5'b00000, 2'b00, 0, 0, 16'd0, 2'd0);
    step("post_rst_run", 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0,  5'b11111, 2'b00, 0, 0, 16'd0, 2'd0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
